io_input_ctrl: RTL

//  Sequences user I/O for the KGP_RISC core. On a CPU input request it stalls the core.
//  It waits for a debounced button press and captures the switch array.
//  The captured value returns to the core zero-extended, with a one-cycle ack.
//  It also holds the display output register written by the core.

---
 rtl/io_input_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/io_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : io_input_ctrl
//  Purpose  : Handles user I/O for the KGP_RISC core. A CPU read stalls until
//             a debounced button press captures the switch array. The block
//             also holds the display output register.
//  Revision : 1.0  initial release
// ============================================================================
module io_input_ctrl #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 5,
    parameter int OUT_W      = 13,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ack,
    output logic              stall,
    output logic              busy,
    input  logic              button,
    input  logic [SW_W-1:0]   array,
    input  logic              wr_en,
    input  logic [OUT_W-1:0]  wr_data,
    output logic [OUT_W-1:0]  out
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_REL   = 2'd1,
        ST_WAIT_PRESS = 2'd2,
        ST_ACK        = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                btn_s1_q, btn_s2_q;
    logic [SW_W-1:0]     arr_s1_q, arr_s2_q;
    logic                deb_q, deb_d;
    logic                deb_dly_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                w_press;

    assign w_press = deb_q & ~deb_dly_q;

    // Debounce: the level only flips after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (btn_s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            deb_d = btn_s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Request sequencing; dropping rd_req while waiting aborts without an ack
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = deb_q ? ST_WAIT_REL : ST_WAIT_PRESS;
                end
            end
            ST_WAIT_REL: begin
                if (!rd_req) begin
                    state_d = ST_IDLE;
                end else if (!deb_q) begin
                    state_d = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (!rd_req) begin
                    state_d = ST_IDLE;
                end else if (w_press) begin
                    rd_data_d = DATA_W'(arr_s2_q);
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (wr_en) begin
            out_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            arr_s1_q  <= '0;
            arr_s2_q  <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            btn_s1_q  <= button;
            btn_s2_q  <= btn_s1_q;
            arr_s1_q  <= array;
            arr_s2_q  <= arr_s1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            out_q     <= out_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = (state_q == ST_ACK);
    assign busy    = (state_q != ST_IDLE);
    assign stall   = rd_req & ~rd_ack;
    assign out     = out_q;

endmodule
`default_nettype wire
